// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with round-robin or
// externally selected arbitration, optional packet locking and a single
// registered output stage (1-cycle latency, 1 beat/clk sustained).
module stream_mux_rr #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SELW     = 2,
  parameter int unsigned PKT_LOCK = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic [SELW-1:0]  sel_q;
  logic             lock_q;
  logic [SELW-1:0]  lock_ch_q;
  logic [SELW-1:0]  rr_q;

  logic             load;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  // Output register may take a new beat when empty or being drained this cycle.
  assign load = !valid_q || out_ready;

  // Grant selection: locked channel, round-robin search after rr_q, or external select.
  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (lock_q) begin
      // Locked channel keeps the grant even when it drops valid (bubble, no interleave).
      grant       = lock_ch_q;
      grant_valid = 1'b1;
    end else if (!mode) begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        if (!grant_valid && in_valid[idx]) begin
          grant       = SELW'(idx);
          grant_valid = 1'b1;
        end
      end
    end else if (32'(sel) < N) begin
      grant       = sel;
      grant_valid = in_valid[sel];
    end
  end

  // Per-channel ready: one-hot on the granted channel when the output can load.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = load && grant_valid && (grant == SELW'(i));
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Route the granted channel's payload toward the output register.
  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        beat_data = in_data[i*WIDTH +: WIDTH];
        beat_last = in_last[i];
      end
    end
  end

  // Output stage, round-robin pointer and packet lock state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      sel_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      rr_q      <= SELW'(N - 1);
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= beat_data;
      last_q  <= beat_last;
      sel_q   <= grant;
      if (!mode) begin
        rr_q <= grant;
      end
      if (PKT_LOCK != 0) begin
        // While locked the grant is the locked channel, so a last beat here ends its packet.
        if (!beat_last) begin
          lock_q    <= 1'b1;
          lock_ch_q <= grant;
        end else begin
          lock_q <= 1'b0;
        end
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, hand-written
// lock/reset/mode sequences, then randomized traffic against a reference model.
module tb_stream_mux_rr;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready = 1'b1;

  // Second instance with N=3 so that an out-of-range select is reachable.
  logic        mode2 = 1'b1;
  logic [1:0]  sel2 = '0;
  logic [23:0] d2 = 24'hC2B1A0;
  logic [2:0]  v2 = '0;
  logic [2:0]  l2 = 3'b111;
  logic [2:0]  r2;
  logic [7:0]  od2;
  logic        ov2;
  logic        ol2;
  logic [1:0]  os2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .WIDTH(8), .SELW(2), .PKT_LOCK(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  stream_mux_rr #(.N(3), .WIDTH(8), .SELW(2), .PKT_LOCK(0)) dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .in_data(d2),
    .in_valid(v2), .in_last(l2), .in_ready(r2),
    .out_data(od2), .out_valid(ov2), .out_last(ol2),
    .out_sel(os2), .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, then check the registered outputs.
  task automatic cyc(input string tag, input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic [3:0] l, input logic o,
                     input logic [31:0] d, input logic [3:0] er, input logic eov,
                     input logic [1:0] es, input logic [7:0] eod);
    @(negedge clk);
    mode = m; sel = s; in_valid = v; in_last = l; out_ready = o; in_data = d;
    #1;
    chk($sformatf("%s_rdy", tag), 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk($sformatf("%s_ov", tag), 32'(out_valid), 32'(eov));
    chk($sformatf("%s_sel", tag), 32'(out_sel), 32'(es));
    chk($sformatf("%s_od", tag), 32'(out_data), 32'(eod));
  endtask

  typedef struct {
    logic        m;
    logic [1:0]  s;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        o;
    logic [31:0] d;
    logic [3:0]  er;
    logic        eov;
    logic [1:0]  es;
    logic [7:0]  eod;
  } vec_t;

  vec_t vecs[16];

  // Reference model state.
  bit       m_ov, m_ol, m_lock;
  bit [7:0] m_od;
  int       m_os, m_lch, m_ptr;

  initial begin
    int  g;
    bit  gv, ld, xf;
    logic [3:0] exp_rdy;

    // Round-robin sweep (ptr starts at 3, so 0 first), fixed select, backpressure.
    vecs[0]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'b0001, 1'b1, 2'd0, 8'h10};
    vecs[1]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'b0010, 1'b1, 2'd1, 8'h11};
    vecs[2]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'b0100, 1'b1, 2'd2, 8'h12};
    vecs[3]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'b1000, 1'b1, 2'd3, 8'h13};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'b0001, 1'b1, 2'd0, 8'h10};
    vecs[5]  = '{1'b1, 2'd2, 4'b0101, 4'b1111, 1'b1, 32'h00A50011, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vecs[6]  = '{1'b1, 2'd3, 4'b0101, 4'b1111, 1'b1, 32'h00A50011, 4'b0000, 1'b0, 2'd2, 8'hA5};
    vecs[7]  = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b1, 32'h00002100, 4'b0010, 1'b1, 2'd1, 8'h21};
    vecs[8]  = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b0, 32'h00002200, 4'b0000, 1'b1, 2'd1, 8'h21};
    vecs[9]  = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b0, 32'h00002200, 4'b0000, 1'b1, 2'd1, 8'h21};
    vecs[10] = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b0, 32'h00002200, 4'b0000, 1'b1, 2'd1, 8'h21};
    vecs[11] = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b1, 32'h00002200, 4'b0010, 1'b1, 2'd1, 8'h22};
    vecs[12] = '{1'b1, 2'd1, 4'b0010, 4'b1111, 1'b1, 32'h00002300, 4'b0010, 1'b1, 2'd1, 8'h23};
    vecs[13] = '{1'b0, 2'd0, 4'b1010, 4'b1111, 1'b1, 32'h44003300, 4'b0010, 1'b1, 2'd1, 8'h33};
    vecs[14] = '{1'b0, 2'd0, 4'b1010, 4'b1111, 1'b1, 32'h44003300, 4'b1000, 1'b1, 2'd3, 8'h44};
    vecs[15] = '{1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1, 32'h44003300, 4'b0000, 1'b0, 2'd3, 8'h44};

    #12;
    rst = 1'b0;

    // Reset state of the main instance.
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // Out-of-range select on the N=3 instance.
    @(negedge clk);
    sel2 = 2'd3; v2 = 3'b111;
    #1;
    chk("n3_sel3_rdy", 32'(r2), 32'd0);
    @(posedge clk); #1;
    chk("n3_sel3_ov", 32'(ov2), 32'd0);
    @(negedge clk);
    sel2 = 2'd2;
    #1;
    chk("n3_sel2_rdy", 32'(r2), 32'b100);
    @(posedge clk); #1;
    chk("n3_sel2_ov", 32'(ov2), 32'd1);
    chk("n3_sel2_od", 32'(od2), 32'hC2);
    @(negedge clk);
    sel2 = 2'd3;
    #1;
    chk("n3_sel3b_rdy", 32'(r2), 32'd0);
    @(posedge clk); #1;
    chk("n3_sel3b_ov", 32'(ov2), 32'd0);
    chk("n3_sel3b_od", 32'(od2), 32'hC2);
    v2 = '0;

    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].m, vecs[i].s, vecs[i].v, vecs[i].l, vecs[i].o,
          vecs[i].d, vecs[i].er, vecs[i].eov, vecs[i].es, vecs[i].eod);
    end

    // Packet lock: ch0 3-beat packet with a gap, ch1 must wait. Order 0,0,0,1.
    cyc("lk_a", 1'b0, 2'd0, 4'b0011, 4'b0010, 1'b1, 32'h0000B0A0, 4'b0001, 1'b1, 2'd0, 8'hA0);
    cyc("lk_gap", 1'b0, 2'd0, 4'b0010, 4'b0010, 1'b1, 32'h0000B0A0, 4'b0001, 1'b0, 2'd0, 8'hA0);
    cyc("lk_b", 1'b0, 2'd0, 4'b0011, 4'b0010, 1'b1, 32'h0000B0A1, 4'b0001, 1'b1, 2'd0, 8'hA1);
    cyc("lk_c", 1'b0, 2'd0, 4'b0011, 4'b0011, 1'b1, 32'h0000B0A2, 4'b0001, 1'b1, 2'd0, 8'hA2);
    cyc("lk_d", 1'b0, 2'd0, 4'b0010, 4'b0011, 1'b1, 32'h0000B0A2, 4'b0010, 1'b1, 2'd1, 8'hB0);

    // Asynchronous reset mid-packet on ch2.
    cyc("ar_a", 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b1, 32'h005A0000, 4'b0100, 1'b1, 2'd2, 8'h5A);
    #2;
    rst = 1'b1;
    in_valid = '0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_od", 32'(out_data), 32'd0);
    chk("ar_sel", 32'(out_sel), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_post_ov", 32'(out_valid), 32'd0);
    cyc("ar_b", 1'b0, 2'd0, 4'b1001, 4'b1111, 1'b1, 32'h3F00005A, 4'b0001, 1'b1, 2'd0, 8'h5A);

    // Mode change while locked on ch1 is ignored until its last beat.
    cyc("md_a", 1'b0, 2'd0, 4'b1010, 4'b0000, 1'b1, 32'hD000C000, 4'b0010, 1'b1, 2'd1, 8'hC0);
    cyc("md_b", 1'b1, 2'd3, 4'b1010, 4'b0000, 1'b1, 32'hD000C100, 4'b0010, 1'b1, 2'd1, 8'hC1);
    cyc("md_c", 1'b1, 2'd3, 4'b1010, 4'b0010, 1'b1, 32'hD000C200, 4'b0010, 1'b1, 2'd1, 8'hC2);
    cyc("md_d", 1'b1, 2'd3, 4'b1010, 4'b1000, 1'b1, 32'hD000C200, 4'b1000, 1'b1, 2'd3, 8'hD0);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    #2;
    rst = 1'b0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_lock = 0; m_lch = 0; m_ptr = N - 1;
    mode = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk("rnd_ov", 32'(out_valid), 32'(m_ov));
      chk("rnd_od", 32'(out_data), 32'(m_od));
      chk("rnd_last", 32'(out_last), 32'(m_ol));
      chk("rnd_sel", 32'(out_sel), 32'(m_os));
      if ($urandom_range(15) == 0) mode = ~mode;
      sel       = 2'($urandom_range(3));
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      in_data   = $urandom;
      #1;
      ld = !m_ov || out_ready;
      g  = 0;
      gv = 0;
      if (m_lock) begin
        g  = m_lch;
        gv = 1;
      end else if (!mode) begin
        for (int k = 1; k <= int'(N); k++) begin
          int ch;
          ch = (m_ptr + k) % N;
          if (!gv && in_valid[ch]) begin
            g  = ch;
            gv = 1;
          end
        end
      end else begin
        g  = int'(sel);
        gv = (g < int'(N)) && in_valid[g];
      end
      exp_rdy = (ld && gv) ? 4'(1 << g) : 4'b0000;
      chk("rnd_rdy", 32'(in_ready), 32'(exp_rdy));
      xf = ld && gv && in_valid[g];
      @(posedge clk);
      if (xf) begin
        m_ov = 1;
        m_od = in_data[g*8 +: 8];
        m_ol = in_last[g];
        m_os = g;
        if (!mode) m_ptr = g;
        if (!in_last[g]) begin
          m_lock = 1;
          m_lch  = g;
        end else begin
          m_lock = 0;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
